// File: rtl/dual_fetch_queue_pkg.sv
// Shared fetch front-end types: datapath widths, queue entry and redirect records.
package core_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  // Canonical NOP (addi x0, x0, 0) for consumers that need a filler encoding.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic            en;
    logic [XLEN-1:0] pc;
  } redirect_t;

  // Redirect targets are word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dual_fetch_queue_if.sv
// Fetch front-end bus: instruction-memory port, back-end redirects and the
// two in-order issue slots towards rename/ROB.
interface dual_fetch_queue_if;
  import core_pkg::*;

  logic               imem_req_en;
  logic [XLEN-1:0]    imem_req_addr;
  logic [INSTR_W-1:0] imem_rdata1;
  logic [INSTR_W-1:0] imem_rdata2;

  logic               ROB_full;
  logic               flush_en;
  logic [XLEN-1:0]    flush_PC;
  logic               branch_en;
  logic [XLEN-1:0]    branch_PC;
  logic               jump_en;
  logic [XLEN-1:0]    jump_PC;

  logic [XLEN-1:0]    PC_in1;
  logic [INSTR_W-1:0] instruction1;
  logic               ins1_valid;
  logic [XLEN-1:0]    PC_in2;
  logic [INSTR_W-1:0] instruction2;
  logic               ins2_valid;

  // Fetch unit side.
  modport master (
    output imem_req_en, imem_req_addr,
    input  imem_rdata1, imem_rdata2,
    input  ROB_full, flush_en, flush_PC, branch_en, branch_PC, jump_en, jump_PC,
    output PC_in1, instruction1, ins1_valid, PC_in2, instruction2, ins2_valid
  );

  // Memory / back-end side.
  modport slave (
    input  imem_req_en, imem_req_addr,
    output imem_rdata1, imem_rdata2,
    output ROB_full, flush_en, flush_PC, branch_en, branch_PC, jump_en, jump_PC,
    input  PC_in1, instruction1, ins1_valid, PC_in2, instruction2, ins2_valid
  );

endinterface

// File: rtl/dual_fetch_queue_fetch_queue.sv
// Circular instruction buffer: pushes two entries at once, pops zero to two
// from the head, with synchronous clear and an occupancy count.
module fetch_queue
  import core_pkg::*;
#(
  parameter int QDEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  fetch_entry_t             i_push_e0,
  input  fetch_entry_t             i_push_e1,
  input  logic [1:0]               i_pop_cnt,
  output fetch_entry_t             o_head0,
  output fetch_entry_t             o_head1,
  output logic [$clog2(QDEPTH):0]  o_count
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  r_mem [QDEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_wr_ptr1;
  logic [AW-1:0] w_rd_ptr1;

  assign w_wr_ptr1 = r_wr_ptr + AW'(1);
  assign w_rd_ptr1 = r_rd_ptr + AW'(1);

  // Storage write: the pair lands in two consecutive slots (pointer wraps).
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr]  <= i_push_e0;
      r_mem[w_wr_ptr1] <= i_push_e1;
    end
  end

  // Pointer/count update; the pop is applied before the push is accounted.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + AW'(i_pop_cnt);
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(2);
      end
      r_count <= r_count - CW'(i_pop_cnt) + (i_push ? CW'(2) : CW'(0));
    end
  end

  assign o_head0 = r_mem[r_rd_ptr];
  assign o_head1 = r_mem[w_rd_ptr1];
  assign o_count = r_count;

endmodule

// File: rtl/dual_fetch_queue.sv
// Dual-issue fetch front end: fetch PC, single outstanding imem request with
// kill-on-redirect, redirect priority mux and the queue-space request rule.
module dual_fetch_queue
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              QDEPTH   = 8
) (
  input  logic                clk,
  input  logic                rst,
  dual_fetch_queue_if.master  bus
);

  localparam int              AW       = $clog2(QDEPTH);
  localparam logic [31:0]     QDEPTH_U = 32'(QDEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_inflight;

  redirect_t       w_redir;
  logic [AW:0]     w_count;
  logic [31:0]     w_need;
  logic            w_req;
  logic            w_push;
  logic            w_v1;
  logic            w_v2;
  logic [1:0]      w_pop_cnt;
  fetch_entry_t    w_push_e0;
  fetch_entry_t    w_push_e1;
  fetch_entry_t    w_head0;
  fetch_entry_t    w_head1;

  // Redirect select: flush beats branch beats jump.
  always_comb begin
    w_redir = '{en: 1'b0, pc: '0};
    if (bus.flush_en) begin
      w_redir = '{en: 1'b1, pc: align_pc(bus.flush_PC)};
    end else if (bus.branch_en) begin
      w_redir = '{en: 1'b1, pc: align_pc(bus.branch_PC)};
    end else if (bus.jump_en) begin
      w_redir = '{en: 1'b1, pc: align_pc(bus.jump_PC)};
    end
  end

  // Request only when the queue is guaranteed room for this pair plus any
  // pair still in flight, judged on the pre-pop count.
  always_comb begin
    w_need = 32'(w_count) + (r_inflight ? 32'd2 : 32'd0) + 32'd2;
    w_req  = !w_redir.en && (w_need <= QDEPTH_U);
  end

  // A response is accepted unless a redirect in its arrival cycle kills it.
  assign w_push    = r_inflight && !w_redir.en;
  assign w_push_e0 = '{pc: r_req_pc,          instr: bus.imem_rdata1};
  assign w_push_e1 = '{pc: r_req_pc + 32'd4,  instr: bus.imem_rdata2};

  // Issue slots pop in the cycle they are valid; slot 2 needs slot 1.
  assign w_v1      = !rst && (w_count >= (AW+1)'(1)) && !bus.ROB_full && !w_redir.en;
  assign w_v2      = !rst && (w_count >= (AW+1)'(2)) && !bus.ROB_full && !w_redir.en;
  assign w_pop_cnt = {1'b0, w_v1} + {1'b0, w_v2};

  // Fetch PC and the in-flight tracker; a redirect drops any outstanding pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else if (w_redir.en) begin
      r_fetch_pc <= w_redir.pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 32'd8;
      end
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_redir.en),
    .i_push    (w_push),
    .i_push_e0 (w_push_e0),
    .i_push_e1 (w_push_e1),
    .i_pop_cnt (w_pop_cnt),
    .o_head0   (w_head0),
    .o_head1   (w_head1),
    .o_count   (w_count)
  );

  assign bus.imem_req_en   = w_req && !rst;
  assign bus.imem_req_addr = rst ? '0 : r_fetch_pc;
  assign bus.ins1_valid    = w_v1;
  assign bus.ins2_valid    = w_v2;
  assign bus.PC_in1        = rst ? '0 : w_head0.pc;
  assign bus.instruction1  = rst ? '0 : w_head0.instr;
  assign bus.PC_in2        = rst ? '0 : w_head1.pc;
  assign bus.instruction2  = rst ? '0 : w_head1.instr;

endmodule
